// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: one transaction at a time, data before instruction,
// with a grant watchdog that raises a sticky error when the RAM never answers.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int unsigned WDW = 16;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, RESP} state_t;

  state_t         state, state_n;
  logic [WDW-1:0] wdog, wdog_n;
  logic           ren_n, wen_n, ihit_n, dhit_n, memerr_n;
  logic [31:0]    addr_n, store_n, iload_n, dload_n;
  logic           grant_req;

  // Request that owns the current grant; dropping it aborts the transaction
  assign grant_req = (state == IGRANT) ? iREN : (dREN | dWEN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wdog     <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      memerr   <= 1'b0;
    end else begin
      state    <= state_n;
      wdog     <= wdog_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      ihit     <= ihit_n;
      dhit     <= dhit_n;
      iload    <= iload_n;
      dload    <= dload_n;
      memerr   <= memerr_n;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_n  = state;
    wdog_n   = wdog;
    ren_n    = 1'b0;
    wen_n    = 1'b0;
    addr_n   = ramaddr;
    store_n  = ramstore;
    ihit_n   = 1'b0;
    dhit_n   = 1'b0;
    iload_n  = iload;
    dload_n  = dload;
    memerr_n = memerr;
    case (state)
      IDLE: begin
        if (dREN | dWEN) begin
          state_n = DGRANT;
          wdog_n  = '0;
          addr_n  = daddr;
          store_n = dstore;
          wen_n   = dWEN;
          ren_n   = ~dWEN;
        end else if (iREN) begin
          state_n = IGRANT;
          wdog_n  = '0;
          addr_n  = iaddr;
          ren_n   = 1'b1;
        end
      end
      IGRANT, DGRANT: begin
        ren_n = ramREN;
        wen_n = ramWEN;
        if (ramstate == RS_ACCESS) begin
          state_n = RESP;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          if (state == IGRANT) begin
            ihit_n  = 1'b1;
            iload_n = ramload;
          end else begin
            dhit_n = 1'b1;
            if (ramREN) dload_n = ramload;
          end
        end else if (ramstate == RS_ERROR) begin
          state_n  = IDLE;
          ren_n    = 1'b0;
          wen_n    = 1'b0;
          memerr_n = 1'b1;
        end else if (!grant_req) begin
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else if (wdog == WD_LAST) begin
          state_n  = IDLE;
          ren_n    = 1'b0;
          wen_n    = 1'b0;
          memerr_n = 1'b1;
        end else if (wdog != WD_MAX) begin
          wdog_n = wdog + 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
